// File: rtl/shift_exec_pipe.sv
// Two-stage shift/rotate execute unit: operand register -> shifter -> result register.
// Optional macro SHIFT_EXEC_PIPE_ZFLAG_EN adds a registered zero-result flag (out_zero).

module shifter (
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out
);
    logic [4:0] w_inv;

    // A 16-bit shift by 16 yields zero, so Cnt=0 rotates reduce to pass-through.
    always_comb begin
        w_inv = 5'd16 - {1'b0, Cnt};
        Out   = In;
        case (Op)
            2'b00:   Out = (In << Cnt) | (In >> w_inv);
            2'b01:   Out = In << Cnt;
            2'b10:   Out = (In >> Cnt) | (In << w_inv);
            default: Out = In >> Cnt;
        endcase
    end
endmodule

module shift_exec_pipe #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_cnt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef SHIFT_EXEC_PIPE_ZFLAG_EN
    ,
    output logic             out_zero
`endif
);
    localparam int DATA_W = 16;

    logic              r_vld_p0;
    logic [DATA_W-1:0] r_data_p0;
    logic [3:0]        r_cnt_p0;
    logic [1:0]        r_op_p0;
    logic [TAG_W-1:0]  r_tag_p0;
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic [TAG_W-1:0]  r_tag_p1;

    logic              w_adv_a;
    logic              w_adv_b;
    logic              w_accept;
    logic              w_load_b;
    logic [DATA_W-1:0] w_shift;

    assign w_adv_b  = ~r_vld_p1 | out_ready;
    assign w_adv_a  = ~r_vld_p0 | w_adv_b;
    assign in_ready = w_adv_a & ~flush & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_load_b = w_adv_b & r_vld_p0;

    assign out_valid = r_vld_p1 & ~flush;
    assign out_data  = r_data_p1;
    assign out_tag   = r_tag_p1;
    assign busy      = r_vld_p0 | r_vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else if (flush) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            if (w_adv_a) r_vld_p0 <= w_accept;
            if (w_adv_b) r_vld_p1 <= r_vld_p0;
        end
    end

    // Stage A boundary: operands captured on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_p0 <= '0;
            r_cnt_p0  <= '0;
            r_op_p0   <= '0;
            r_tag_p0  <= '0;
        end else if (w_accept) begin
            r_data_p0 <= in_data;
            r_cnt_p0  <= in_cnt;
            r_op_p0   <= in_op;
            r_tag_p0  <= in_tag;
        end
    end

    shifter u_shifter (
        .In  (r_data_p0),
        .Cnt (r_cnt_p0),
        .Op  (r_op_p0),
        .Out (w_shift)
    );

    // Stage B boundary: result held while writeback stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_p1 <= '0;
            r_tag_p1  <= '0;
        end else if (w_load_b) begin
            r_data_p1 <= w_shift;
            r_tag_p1  <= r_tag_p0;
        end
    end

`ifdef SHIFT_EXEC_PIPE_ZFLAG_EN
    logic r_zero_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_zero_p1 <= 1'b0;
        else if (w_load_b) r_zero_p1 <= (w_shift == '0);
    end

    assign out_zero = r_zero_p1;
`endif
endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed bench for shift_exec_pipe: basic ops, pass-through, backpressure, flush, async reset.
// Zero-flag checks are compiled in when SHIFT_EXEC_PIPE_ZFLAG_EN is defined.

module tb_shift_exec_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic [2:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_tag;
    logic        busy;
`ifdef SHIFT_EXEC_PIPE_ZFLAG_EN
    logic        out_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0]  v_op   [8];
    logic [15:0] v_data [8];
    logic [3:0]  v_cnt  [8];
    logic [2:0]  v_tag  [8];
    logic [15:0] v_exp  [8];

    localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRL = 2'b11;

    always #5 clk = ~clk;

    shift_exec_pipe #(.TAG_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
`ifdef SHIFT_EXEC_PIPE_ZFLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] c, input logic [2:0] t);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_cnt   = c;
        in_tag   = t;
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic [15:0] d,
                           input logic [3:0] c, input logic [2:0] t, input logic [15:0] e);
        v_op[i]   = op;
        v_data[i] = d;
        v_cnt[i]  = c;
        v_tag[i]  = t;
        v_exp[i]  = e;
    endtask

    // Back-to-back stream with out_ready=1; result i is visible after the edge that accepts i+1.
    task automatic run_stream(input string name, input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(1'b1, v_op[i], v_data[i], v_cnt[i], v_tag[i]);
            else       drive(1'b0, 2'b00, 16'h0000, 4'h0, 3'h0);
            tick();
            if (i == 0) begin
                chk({name, "_first_empty"}, 32'(out_valid), 32'h0);
            end else begin
                chk($sformatf("%s_valid%0d", name, i - 1), 32'(out_valid), 32'h1);
                chk($sformatf("%s_data%0d", name, i - 1), 32'(out_data), 32'(v_exp[i-1]));
                chk($sformatf("%s_tag%0d", name, i - 1), 32'(out_tag), 32'(v_tag[i-1]));
`ifdef SHIFT_EXEC_PIPE_ZFLAG_EN
                chk($sformatf("%s_zero%0d", name, i - 1), 32'(out_zero),
                    32'(v_exp[i-1] == 16'h0000));
`endif
            end
        end
        tick();
        chk({name, "_drained"}, 32'(out_valid), 32'h0);
        chk({name, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 3'h0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);

        // Basic operations
        set_vec(0, ROL, 16'h8001, 4'd1,  3'd1, 16'h0003);
        set_vec(1, SLL, 16'h8001, 4'd1,  3'd2, 16'h0002);
        set_vec(2, ROR, 16'h0001, 4'd4,  3'd3, 16'h1000);
        set_vec(3, SRL, 16'hF000, 4'd12, 3'd4, 16'h000F);
        run_stream("basic", 4);

        // Pass-through and half-word rotates
        set_vec(0, ROL, 16'hA5C3, 4'd0, 3'd0, 16'hA5C3);
        set_vec(1, SLL, 16'hA5C3, 4'd0, 3'd1, 16'hA5C3);
        set_vec(2, ROR, 16'hA5C3, 4'd0, 3'd2, 16'hA5C3);
        set_vec(3, SRL, 16'hA5C3, 4'd0, 3'd3, 16'hA5C3);
        set_vec(4, ROL, 16'h1234, 4'd8, 3'd4, 16'h3412);
        set_vec(5, ROR, 16'h1234, 4'd8, 3'd5, 16'h3412);
        set_vec(6, SLL, 16'hFFFF, 4'd15, 3'd6, 16'h8000);
        set_vec(7, SRL, 16'hFFFF, 4'd15, 3'd7, 16'h0001);
        run_stream("pass", 8);

        // Backpressure: three requests against a stalled writeback
        out_ready = 1'b0;
        drive(1'b1, SLL, 16'h0001, 4'd1, 3'd5);
        #1;
        chk("bp_ready_empty", 32'(in_ready), 32'h1);
        tick();
        chk("bp_out_empty", 32'(out_valid), 32'h0);
        chk("bp_ready_one", 32'(in_ready), 32'h1);
        drive(1'b1, SLL, 16'h0001, 4'd2, 3'd6);
        tick();
        chk("bp_ready_full", 32'(in_ready), 32'h0);
        chk("bp_valid5", 32'(out_valid), 32'h1);
        chk("bp_tag5", 32'(out_tag), 32'h5);
        drive(1'b1, SLL, 16'h0001, 4'd3, 3'd7);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_hold_ready", 32'(in_ready), 32'h0);
            chk("bp_hold_data", 32'(out_data), 32'h0002);
            chk("bp_hold_tag", 32'(out_tag), 32'h5);
            chk("bp_hold_busy", 32'(busy), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 3'h0);
        chk("bp_valid6", 32'(out_valid), 32'h1);
        chk("bp_data6", 32'(out_data), 32'h0004);
        chk("bp_tag6", 32'(out_tag), 32'h6);
        tick();
        chk("bp_valid7", 32'(out_valid), 32'h1);
        chk("bp_data7", 32'(out_data), 32'h0008);
        chk("bp_tag7", 32'(out_tag), 32'h7);
        tick();
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Flush with two operations in flight
        drive(1'b1, ROL, 16'hFFFF, 4'd1, 3'd1);
        tick();
        drive(1'b1, ROL, 16'h00FF, 4'd4, 3'd2);
        tick();
        chk("fl_pre_valid", 32'(out_valid), 32'h1);
        drive(1'b1, SLL, 16'h0003, 4'd2, 3'd3);
        flush = 1'b1;
        #1;
        chk("fl_out_valid", 32'(out_valid), 32'h0);
        chk("fl_in_ready", 32'(in_ready), 32'h0);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 3'h0);
        chk("fl_busy", 32'(busy), 32'h0);
        chk("fl_after_valid", 32'(out_valid), 32'h0);
        tick();
        chk("fl_nothing", 32'(out_valid), 32'h0);
        drive(1'b1, SLL, 16'h0001, 4'd15, 3'd4);
        tick();
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 3'h0);
        chk("fl_new_lat1", 32'(out_valid), 32'h0);
        tick();
        chk("fl_new_valid", 32'(out_valid), 32'h1);
        chk("fl_new_data", 32'(out_data), 32'h8000);
        chk("fl_new_tag", 32'(out_tag), 32'h4);
        tick();
        chk("fl_new_drained", 32'(out_valid), 32'h0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, SRL, 16'hF0F0, 4'd4, 3'd1);
        tick();
        drive(1'b1, SRL, 16'hF0F0, 4'd8, 3'd2);
        tick();
        drive(1'b0, 2'b00, 16'h0000, 4'h0, 3'h0);
        chk("ar_pre_busy", 32'(busy), 32'h1);
        chk("ar_pre_data", 32'(out_data), 32'h0F0F);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_out_data", 32'(out_data), 32'h0);
        chk("ar_out_tag", 32'(out_tag), 32'h0);
        chk("ar_in_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ar_rel_ready", 32'(in_ready), 32'h1);
        chk("ar_rel_valid", 32'(out_valid), 32'h0);
        set_vec(0, ROR, 16'h00F0, 4'd4, 3'd6, 16'h000F);
        set_vec(1, SRL, 16'h00FF, 4'd8, 3'd1, 16'h0000);
        set_vec(2, ROL, 16'h0000, 4'd3, 3'd2, 16'h0000);
        set_vec(3, SLL, 16'h0001, 4'd3, 3'd3, 16'h0008);
        run_stream("resume", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_exec_pipe.md
Name: shift_exec_pipe

Overview:
- Two-stage pipelined execute unit for shift/rotate instructions in the 16-bit custom CPU.
- Accepts decoded shift requests from the issue/decode stage using a valid/ready handshake.
- Registers the operands, drives the combinational `shifter` instance (In/Cnt/Op), and registers the result with its destination tag toward writeback.
- Supports backpressure, pipeline flush, and sustains one operation per cycle.

Parameters:
- TAG_W, 3, width of the destination-register tag carried alongside each operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid from decode.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  16  operand to shift.
- in_cnt  input  4  shift amount, 0-15.
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL.
- in_tag  input  TAG_W  destination register id.
- flush  input  1  discard all in-flight operations.
- out_valid  output  1  result valid to writeback.
- out_ready  input  1  writeback accepts the result.
- out_data  output  16  shifted result.
- out_tag  output  TAG_W  tag of out_data.
- busy  output  1  high when either stage holds a valid operation.

Behaviour:
- Reset (async, rst=1):
  - Stage A registers (a_valid, a_data, a_cnt, a_op, a_tag) clear to 0.
  - Stage B registers (b_valid, b_data, b_tag) clear to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_tag=0, busy=0.
  - in_ready=0 while rst is high; 1 in the first cycle after release.
  - Reset mid-operation drops all contents; nothing is emitted.
- Stage A: captures the request on accept (in_valid & in_ready).
- Stage A feeds the shifter: a_data→In, a_cnt→Cnt, a_op→Op. Shifter output is combinational.
- Stage B: captures the shifter output and a_tag when Stage A advances.
- Advance conditions:
  - adv_b = ~b_valid | out_ready.
  - adv_a = ~a_valid | adv_b.
  - in_ready = adv_a & ~flush & ~rst.
- Registered valids are updated each clock edge (normal operation):
  - a_valid ← accept when adv_a; otherwise holds.
  - b_valid ← a_valid when adv_b; otherwise holds.
- Latency: 2 cycles from the accept edge to out_valid, given no backpressure. Throughput is 1 per cycle.
- Output mapping: out_valid = b_valid & ~flush; out_data = b_data; out_tag = b_tag.
- Ordering: strictly FIFO; no reordering.
- Backpressure:
  - When out_ready=0 and both stages are valid, both stages hold and in_ready=0.
  - The unit holds at most 2 operations.
- Register stability: out_data and out_tag must not change while out_valid=1 and out_ready=0.
- Simultaneous events: when b_valid & out_ready & a_valid, Stage B reloads from A in the same cycle that A reloads from input. No bubble.
- Flush:
  - Has priority over everything except rst.
  - At the next edge, a_valid and b_valid are cleared.
  - A request presented during flush is not accepted (in_ready=0).
  - A result presented during flush is not transferred (out_valid forced 0).
  - Data registers are not cleared by flush.
- Shift semantics, all with Cnt 0 = pass-through:
  - ROL/ROR are rotates modulo 16.
  - SLL/SRL zero-fill.
  - No arithmetic right shift.
- busy = a_valid | b_valid.

Optional Feature:
- Macro: SHIFT_EXEC_PIPE_ZFLAG_EN.
- When defined:
  - Adds output port out_zero (1 bit), registered in Stage B alongside b_data.
  - out_zero = 1 iff the stored result is 0x0000.
  - Reset value 0; holds under backpressure like out_data.
- When not defined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Basic ops, out_ready=1, one request per cycle:
  - ROL 0x8001 cnt1 → 0x0003.
  - SLL 0x8001 cnt1 → 0x0002.
  - ROR 0x0001 cnt4 → 0x1000.
  - SRL 0xF000 cnt12 → 0x000F.
  - Each appears exactly 2 cycles after its accept, with matching tags 1-4, back-to-back.
- Pass-through: every op with cnt0 on 0xA5C3 → 0xA5C3. Rotates ROL 0x1234 cnt8 → 0x3412 and ROR 0x1234 cnt8 → 0x3412.
- Backpressure:
  - Send 3 requests (tags 5, 6, 7) with out_ready=0.
  - in_ready drops after 2 accepts; out_data/out_tag stay at tag 5 unchanged.
  - Raise out_ready: tags 5, 6, 7 emerge in order on consecutive cycles.
- Flush with 2 in flight:
  - Assert flush for 1 cycle with out_ready=1: out_valid=0 that cycle, busy=0 next cycle.
  - Nothing from the flushed ops is ever emitted.
  - The next request (SLL 0x0001 cnt15 → 0x8000) emerges 2 cycles after its accept.
- Async reset mid-operation:
  - Assert rst between clock edges with both stages full.
  - out_valid and busy fall to 0 immediately; out_data=0.
  - After release, in_ready=1 and normal operation resumes.
- With ZFLAG_EN:
  - SRL 0x00FF cnt8 → out_data 0x0000, out_zero=1.
  - ROL 0x0000 cnt3 → out_zero=1.
  - SLL 0x0001 cnt3 → 0x0008, out_zero=0.
